// File: rtl/axis_bram_frame_writer.sv
// AXI4-Stream to BRAM port-A frame writer: one word per accepted beat at addresses 0..cfg_data.
// Single-shot (stops in DONE) or continuous ring-buffer capture, with progress/done status.
module axis_bram_frame_writer #(
  parameter int    AXIS_TDATA_WIDTH = 32,
  parameter int    BRAM_DATA_WIDTH  = 32,
  parameter int    BRAM_ADDR_WIDTH  = 10,
  parameter string CONTINUOUS       = "FALSE"
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         cfg_start,
  input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_data,
  output logic [BRAM_ADDR_WIDTH:0]     sts_data,
  output logic                         sts_done,
  input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic                         b_bram_clk,
  output logic                         b_bram_rst,
  output logic                         b_bram_en,
  output logic [BRAM_DATA_WIDTH/8-1:0] b_bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0]   b_bram_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   b_bram_wdata
);

  localparam bit CONT_MODE = (CONTINUOUS == "TRUE");
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = {{(BRAM_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BRAM_ADDR_WIDTH:0]   CNT_ONE  = {{BRAM_ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                       state_q, state_n;
  logic [BRAM_ADDR_WIDTH-1:0]   addr_q, addr_n;
  logic [BRAM_ADDR_WIDTH-1:0]   cfg_q, cfg_n;
  logic [BRAM_ADDR_WIDTH:0]     count_q, count_n;
  logic                         done_q, done_n;
  logic                         start_d;
  logic                         arm;
  logic                         beat;
  logic                         end_beat;

  assign arm      = cfg_start & ~start_d;
  assign beat     = s_axis_tvalid & s_axis_tready;
  assign end_beat = beat & ((addr_q == cfg_q) | s_axis_tlast);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cfg_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      start_d <= 1'b0;
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      cfg_q   <= cfg_n;
      count_q <= count_n;
      done_q  <= done_n;
      start_d <= cfg_start;
    end
  end

  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    cfg_n   = cfg_q;
    count_n = count_q;
    done_n  = done_q;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_n = S_RUN;
          cfg_n   = cfg_data;
          addr_n  = '0;
          count_n = '0;
          done_n  = 1'b0;
        end
      end
      S_RUN: begin
        if (beat) begin
          if (end_beat && CONT_MODE) begin
            addr_n  = '0;
            count_n = '0;
          end else if (end_beat) begin
            count_n = count_q + CNT_ONE;
            done_n  = 1'b1;
            state_n = S_DONE;
          end else begin
            addr_n  = addr_q + ADDR_ONE;
            count_n = count_q + CNT_ONE;
          end
        end
        // Abort wins over completion, but the beat of this cycle is still written and counted.
        if (!cfg_start) begin
          state_n = S_IDLE;
          done_n  = 1'b0;
        end
      end
      S_DONE: begin
        if (!cfg_start) begin
          state_n = S_IDLE;
          done_n  = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign s_axis_tready = (state_q == S_RUN);
  assign sts_data      = count_q;
  assign sts_done      = done_q;
  assign b_bram_clk    = aclk;
  assign b_bram_rst    = areset;
  assign b_bram_en     = beat;
  assign b_bram_we     = {(BRAM_DATA_WIDTH/8){beat}};
  assign b_bram_addr   = addr_q;
  assign b_bram_wdata  = s_axis_tdata;

endmodule

// File: tb/tb_axis_bram_frame_writer.sv
// Directed bench for axis_bram_frame_writer: a single-shot and a continuous instance share the
// stream; a per-cycle vector table covers capture/tlast/abort, hand sequences the rest.
module tb_axis_bram_frame_writer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start_s, start_c;
  logic [9:0]  cfg_data;
  logic [31:0] tdata;
  logic        tvalid, tlast;

  logic [10:0] sts_s, sts_c;
  logic        done_s, done_c, ready_s, ready_c;
  logic        clk_s, clk_c, rst_s, rst_c, en_s, en_c;
  logic [3:0]  we_s, we_c;
  logic [9:0]  addr_s, addr_c;
  logic [31:0] wdata_s, wdata_c;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem [0:1023];

  always #5 aclk = ~aclk;

  axis_bram_frame_writer u_single (
    .aclk(aclk), .areset(areset), .cfg_start(start_s), .cfg_data(cfg_data),
    .sts_data(sts_s), .sts_done(done_s), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tready(ready_s), .b_bram_clk(clk_s), .b_bram_rst(rst_s),
    .b_bram_en(en_s), .b_bram_we(we_s), .b_bram_addr(addr_s), .b_bram_wdata(wdata_s)
  );

  axis_bram_frame_writer #(.CONTINUOUS("TRUE")) u_cont (
    .aclk(aclk), .areset(areset), .cfg_start(start_c), .cfg_data(cfg_data),
    .sts_data(sts_c), .sts_done(done_c), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tready(ready_c), .b_bram_clk(clk_c), .b_bram_rst(rst_c),
    .b_bram_en(en_c), .b_bram_we(we_c), .b_bram_addr(addr_c), .b_bram_wdata(wdata_c)
  );

  // BRAM port model behind the single-shot instance
  always @(posedge clk_s) begin
    if (en_s && we_s == 4'hF) mem[addr_s] <= wdata_s;
  end

  typedef struct {
    logic        start;
    logic [9:0]  cfg;
    logic        tvalid;
    logic        tlast;
    logic [31:0] tdata;
    logic        ready;
    logic        en;
    logic [9:0]  addr;
    logic [10:0] sts;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(logic st, logic tv, logic tl, logic [31:0] td,
                                 logic rdy, logic en, logic [9:0] ad, logic [10:0] sd, logic dn);
    vec_t v;
    v.start = st; v.cfg = 10'd7; v.tvalid = tv; v.tlast = tl; v.tdata = td;
    v.ready = rdy; v.en = en; v.addr = ad; v.sts = sd; v.done = dn;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    @(negedge aclk);
    start_s = v.start; cfg_data = v.cfg; tvalid = v.tvalid; tlast = v.tlast; tdata = v.tdata;
    #1;
    tag = $sformatf("row%0d", idx);
    checkOutput({tag, " tready"}, ready_s, v.ready);
    checkOutput({tag, " en"}, en_s, v.en);
    checkOutput({tag, " we"}, we_s, {4{v.en}});
    checkOutput({tag, " addr"}, addr_s, v.addr);
    checkOutput({tag, " sts_data"}, sts_s, v.sts);
    checkOutput({tag, " sts_done"}, done_s, v.done);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] exp_mem [0:7];
    int beats;
    logic exp_ready;

    // single-shot capture of 0..7 with a stalled 9th beat
    vecs.push_back(mkVec(0, 0, 0, 32'h0,   0, 0, 10'd0, 11'd0, 0));
    vecs.push_back(mkVec(1, 1, 0, 32'hAA,  0, 0, 10'd0, 11'd0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mkVec(1, 1, 0, i, 1, 1, i[9:0], i[10:0], 0));
    vecs.push_back(mkVec(1, 1, 0, 32'h8,   0, 0, 10'd7, 11'd8, 1));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,   0, 0, 10'd7, 11'd8, 1));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,   0, 0, 10'd7, 11'd8, 0));
    // early end on tlast of beat 3
    vecs.push_back(mkVec(1, 0, 0, 32'h0,   0, 0, 10'd7, 11'd8, 0));
    vecs.push_back(mkVec(1, 1, 0, 32'h100, 1, 1, 10'd0, 11'd0, 0));
    vecs.push_back(mkVec(1, 1, 0, 32'h101, 1, 1, 10'd1, 11'd1, 0));
    vecs.push_back(mkVec(1, 1, 1, 32'h102, 1, 1, 10'd2, 11'd2, 0));
    vecs.push_back(mkVec(1, 1, 0, 32'h103, 0, 0, 10'd2, 11'd3, 1));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,   0, 0, 10'd2, 11'd3, 1));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,   0, 0, 10'd2, 11'd3, 0));
    // abort after 5 beats (one gap), then re-arm
    vecs.push_back(mkVec(1, 0, 0, 32'h0,   0, 0, 10'd2, 11'd3, 0));
    vecs.push_back(mkVec(1, 1, 0, 32'h200, 1, 1, 10'd0, 11'd0, 0));
    vecs.push_back(mkVec(1, 0, 0, 32'h0,   1, 0, 10'd1, 11'd1, 0));
    vecs.push_back(mkVec(1, 1, 0, 32'h201, 1, 1, 10'd1, 11'd1, 0));
    vecs.push_back(mkVec(1, 1, 0, 32'h202, 1, 1, 10'd2, 11'd2, 0));
    vecs.push_back(mkVec(1, 1, 0, 32'h203, 1, 1, 10'd3, 11'd3, 0));
    vecs.push_back(mkVec(0, 1, 0, 32'h204, 1, 1, 10'd4, 11'd4, 0));
    vecs.push_back(mkVec(0, 1, 0, 32'h205, 0, 0, 10'd5, 11'd5, 0));
    vecs.push_back(mkVec(1, 0, 0, 32'h0,   0, 0, 10'd5, 11'd5, 0));
    vecs.push_back(mkVec(1, 0, 0, 32'h0,   1, 0, 10'd0, 11'd0, 0));
    vecs.push_back(mkVec(1, 1, 0, 32'h300, 1, 1, 10'd0, 11'd0, 0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,   1, 0, 10'd1, 11'd1, 0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,   0, 0, 10'd1, 11'd1, 0));

    exp_mem[0] = 32'h300; exp_mem[1] = 32'h201; exp_mem[2] = 32'h202; exp_mem[3] = 32'h203;
    exp_mem[4] = 32'h204; exp_mem[5] = 32'h5;   exp_mem[6] = 32'h6;   exp_mem[7] = 32'h7;

    areset = 1'b1; start_s = 1'b0; start_c = 1'b0; cfg_data = 10'd7;
    tdata = '0; tvalid = 1'b0; tlast = 1'b0;
    repeat (2) @(negedge aclk);
    #1;
    checkOutput("reset tready", ready_s, 0);
    checkOutput("reset en", en_s, 0);
    checkOutput("reset addr", addr_s, 0);
    checkOutput("reset sts_data", sts_s, 0);
    checkOutput("reset sts_done", done_s, 0);
    checkOutput("reset bram_rst", rst_s, 1);
    checkOutput("bram_clk follows aclk", clk_s, 0);
    #1 areset = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    for (int i = 0; i < 8; i++) checkOutput($sformatf("mem[%0d]", i), mem[i], exp_mem[i]);

    // single-shot, cfg 15, random valid gaps
    @(negedge aclk);
    start_s = 1'b1; cfg_data = 10'd15; tvalid = 1'b0;
    beats = 0;
    for (int cyc = 0; cyc < 300 && beats < 16; cyc++) begin
      @(negedge aclk);
      tvalid = 1'($urandom_range(0, 1));
      tdata  = 32'h400 + beats;
      #1;
      exp_ready = 1'b1;
      checkOutput("gap tready", ready_s, exp_ready);
      checkOutput("gap en", en_s, tvalid);
      checkOutput("gap we", we_s, {4{tvalid}});
      if (tvalid) begin
        checkOutput("gap addr", addr_s, beats);
        beats++;
      end
    end
    checkOutput("gap beat count (timeout)", beats, 16);
    @(negedge aclk);
    tvalid = 1'b1; tdata = 32'hDEAD;
    #1;
    checkOutput("gap end tready", ready_s, 0);
    checkOutput("gap end en", en_s, 0);
    checkOutput("gap end sts_data", sts_s, 16);
    checkOutput("gap end sts_done", done_s, 1);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("gap mem[%0d]", i), mem[i], 32'h400 + i);

    // continuous ring, cfg 3, 10 beats
    @(negedge aclk);
    start_c = 1'b1; cfg_data = 10'd3; tvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      tvalid = 1'b1; tdata = 32'h500 + i;
      #1;
      checkOutput($sformatf("ring tready %0d", i), ready_c, 1);
      checkOutput($sformatf("ring en %0d", i), en_c, 1);
      checkOutput($sformatf("ring we %0d", i), we_c, 4'hF);
      checkOutput($sformatf("ring addr %0d", i), addr_c, i % 4);
      checkOutput($sformatf("ring sts_data %0d", i), sts_c, i % 4);
      checkOutput($sformatf("ring wdata %0d", i), wdata_c, 32'h500 + i);
      checkOutput($sformatf("ring sts_done %0d", i), done_c, 0);
    end
    @(negedge aclk);
    tvalid = 1'b0;
    #1;
    checkOutput("ring final sts_data", sts_c, 2);
    checkOutput("ring final tready", ready_c, 1);
    checkOutput("ring final sts_done", done_c, 0);

    // asynchronous reset pulse mid-run, cfg_start held high
    tvalid = 1'b1; tdata = 32'h600;
    #1;
    checkOutput("pre-reset en", en_c, 1);
    @(negedge aclk);
    #2 areset = 1'b1;
    #1;
    checkOutput("async tready", ready_c, 0);
    checkOutput("async en", en_c, 0);
    checkOutput("async sts_data", sts_c, 0);
    checkOutput("async addr", addr_c, 0);
    checkOutput("async single sts_done", done_s, 0);
    checkOutput("async bram_rst", rst_c, 1);
    tvalid = 1'b0;
    #1 areset = 1'b0;
    @(negedge aclk);
    #1;
    checkOutput("rearm tready", ready_c, 1);
    checkOutput("rearm addr", addr_c, 0);
    checkOutput("rearm sts_data", sts_c, 0);
    checkOutput("bram_clk low phase", clk_c, 0);
    tvalid = 1'b1; tdata = 32'h700;
    @(negedge aclk);
    tvalid = 1'b0;
    #1;
    checkOutput("rearm beat sts_data", sts_c, 1);
    checkOutput("rearm beat addr", addr_c, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
